ps2_scan_rx: RTL and testbench

//  PS/2 keyboard receiver and scancode framer. Oversamples the PS/2 clock and data lines,

---
 rtl/ps2_scan_rx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames, folds
// E0/F0 prefixes into flags and queues {ext, brk, code} entries for a valid/ready consumer.
module ps2_scan_rx #(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_code,
   output logic       out_ext,
   output logic       out_brk,
   output logic       overflow,
   input  logic       clr_overflow,
   output logic [7:0] err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par_bit);
      return (^data_byte) ^ par_bit;
   endfunction

   logic          clk_s1_r, clk_s2_r, clk_prev_r;
   logic          data_s1_r, data_s2_r;
   state_t        state_r, state_next_s;
   logic [2:0]    bitcnt_r;
   logic [7:0]    shift_r;
   logic          parity_r;
   logic [TW-1:0] to_cnt_r;
   logic          ext_pend_r, brk_pend_r;
   logic [9:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
   logic [CW-1:0] count_r, cnt_next_s, cnt_after_pop_s;
   logic [9:0]    head_r, head_next_s, push_entry_s;
   logic          out_valid_r, overflow_r;
   logic [7:0]    err_cnt_r;
   logic          fall_s, timeout_s, err_s, accept_s, push_s;
   logic          pop_s, full_s, push_ok_s, drop_s;

   assign fall_s    = clk_prev_r & ~clk_s2_r;
   assign timeout_s = (state_r != ST_IDLE) && !fall_s && (to_cnt_r == TO_LAST);
   assign push_s    = accept_s && (shift_r != 8'hE0) && (shift_r != 8'hF0);
   assign push_entry_s = {ext_pend_r, brk_pend_r, shift_r};

   // Receive FSM next-state and frame events.
   always_comb begin
      state_next_s = state_r;
      err_s        = 1'b0;
      accept_s     = 1'b0;
      if (timeout_s) begin
         state_next_s = ST_IDLE;
         err_s        = 1'b1;
      end else if (fall_s) begin
         case (state_r)
            ST_IDLE: begin
               if (!data_s2_r) begin
                  state_next_s = ST_DATA;
               end else begin
                  err_s = 1'b1;
               end
            end
            ST_DATA: begin
               if (bitcnt_r == 3'd7) begin
                  state_next_s = ST_PARITY;
               end else begin
                  state_next_s = ST_DATA;
               end
            end
            ST_PARITY: state_next_s = ST_STOP;
            ST_STOP: begin
               state_next_s = ST_IDLE;
               if (data_s2_r && odd_parity_ok(shift_r, parity_r)) begin
                  accept_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
            end
            default: state_next_s = ST_IDLE;
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // FIFO bookkeeping and the head entry that will be visible next cycle.
   always_comb begin
      pop_s           = out_valid_r & out_ready;
      full_s          = (count_r == FULL_CNT);
      push_ok_s       = push_s & (~full_s | pop_s);
      drop_s          = push_s & full_s & ~pop_s;
      cnt_after_pop_s = count_r - CW'(pop_s);
      cnt_next_s      = cnt_after_pop_s + CW'(push_ok_s);
      rd_next_s       = pop_s ? rd_ptr_r + 1'b1 : rd_ptr_r;
      if (cnt_next_s == {CW{1'b0}}) begin
         head_next_s = 10'd0;
      end else if (push_ok_s && (cnt_after_pop_s == {CW{1'b0}})) begin
         head_next_s = push_entry_s;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end
   end

   // Synchronisers, receive datapath, prefix flags, FIFO control and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_r    <= 1'b1;
         clk_s2_r    <= 1'b1;
         clk_prev_r  <= 1'b1;
         data_s1_r   <= 1'b1;
         data_s2_r   <= 1'b1;
         state_r     <= ST_IDLE;
         bitcnt_r    <= 3'd0;
         shift_r     <= 8'd0;
         parity_r    <= 1'b0;
         to_cnt_r    <= {TW{1'b0}};
         ext_pend_r  <= 1'b0;
         brk_pend_r  <= 1'b0;
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         head_r      <= 10'd0;
         out_valid_r <= 1'b0;
         overflow_r  <= 1'b0;
         err_cnt_r   <= 8'd0;
      end else begin
         clk_s1_r   <= ps2_clk;
         clk_s2_r   <= clk_s1_r;
         clk_prev_r <= clk_s2_r;
         data_s1_r  <= ps2_data;
         data_s2_r  <= data_s1_r;
         state_r    <= state_next_s;

         if (fall_s && state_r == ST_IDLE) begin
            bitcnt_r <= 3'd0;
         end else if (fall_s && state_r == ST_DATA) begin
            shift_r  <= {data_s2_r, shift_r[7:1]};
            bitcnt_r <= bitcnt_r + 3'd1;
         end else if (fall_s && state_r == ST_PARITY) begin
            parity_r <= data_s2_r;
         end

         if (state_r == ST_IDLE || fall_s) begin
            to_cnt_r <= {TW{1'b0}};
         end else begin
            to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
         end

         // Prefixes accumulate until a real code consumes them; any error forgets them.
         if (err_s) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
            if (err_cnt_r != 8'hFF) begin
               err_cnt_r <= err_cnt_r + 8'd1;
            end
         end else if (accept_s && shift_r == 8'hE0) begin
            ext_pend_r <= 1'b1;
         end else if (accept_s && shift_r == 8'hF0) begin
            brk_pend_r <= 1'b1;
         end else if (accept_s) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
         end

         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         rd_ptr_r    <= rd_next_s;
         count_r     <= cnt_next_s;
         head_r      <= head_next_s;
         out_valid_r <= (cnt_next_s != {CW{1'b0}});

         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clr_overflow) begin
            overflow_r <= 1'b0;
         end
      end
   end

   // FIFO storage; contents need no reset since occupancy is tracked by count_r.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_entry_s;
      end
   end

   assign out_valid = out_valid_r;
   assign out_code  = head_r[7:0];
   assign out_brk   = head_r[8];
   assign out_ext   = head_r[9];
   assign overflow  = overflow_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: bit-bangs PS/2 frames and checks queued codes,
// prefix flags, error counting, timeout, FIFO overflow and reset behaviour.
module tb_ps2_scan_rx;

   localparam int TIMEOUT_CYC = 5000;
   localparam int HALF        = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_code;
   logic       out_ext;
   logic       out_brk;
   logic       overflow;
   logic       clr_overflow = 1'b0;
   logic [7:0] err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   ps2_scan_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .out_ext(out_ext), .out_brk(out_brk), .overflow(overflow),
      .clr_overflow(clr_overflow), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par,
                                              input logic stop);
      return {stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic send_raw(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         tick(HALF);
         ps2_clk = 1'b0;
         tick(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      tick(HALF + 4);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      send_raw(frame_bits(b, bad_par, stop), 11);
   endtask

   task automatic pop_expect(input string tag, input logic ext, input logic brk,
                             input logic [7:0] code);
      check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, "_entry"}, {22'd0, out_ext, out_brk, out_code}, {22'd0, ext, brk, code});
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      tick(1);
      do_reset();
      check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_entry", {22'd0, out_ext, out_brk, out_code}, 32'd0);
      check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
      check_eq("rst_err", {24'd0, err_cnt}, 32'd0);

      // 1: single code, held while not ready
      send_frame(8'h1C, 1'b0, 1'b1);
      check_eq("t1_valid", {31'd0, out_valid}, 32'd1);
      check_eq("t1_entry", {22'd0, out_ext, out_brk, out_code}, 32'h01C);
      check_eq("t1_err", {24'd0, err_cnt}, 32'd0);
      tick(20);
      pop_expect("t1_hold", 1'b0, 1'b0, 8'h1C);
      check_eq("t1_empty", {31'd0, out_valid}, 32'd0);

      // 2: prefix folding
      do_reset();
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      pop_expect("t2_a", 1'b0, 1'b1, 8'h1C);
      pop_expect("t2_b", 1'b1, 1'b1, 8'h75);
      check_eq("t2_empty", {31'd0, out_valid}, 32'd0);

      // 3: parity error, and error clearing a pending prefix
      do_reset();
      send_frame(8'h1C, 1'b1, 1'b1);
      check_eq("t3_nopush", {31'd0, out_valid}, 32'd0);
      check_eq("t3_err1", {24'd0, err_cnt}, 32'd1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h33, 1'b1, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      check_eq("t3_err2", {24'd0, err_cnt}, 32'd2);
      pop_expect("t3_clr", 1'b0, 1'b0, 8'h1C);

      // 4: timeout on a partial frame
      do_reset();
      send_raw(frame_bits(8'h29, 1'b0, 1'b1), 5);
      tick(TIMEOUT_CYC - 100);
      check_eq("t4_early", {24'd0, err_cnt}, 32'd0);
      tick(120);
      check_eq("t4_to", {24'd0, err_cnt}, 32'd1);
      send_frame(8'h29, 1'b0, 1'b1);
      pop_expect("t4_rx", 1'b0, 1'b0, 8'h29);
      check_eq("t4_err", {24'd0, err_cnt}, 32'd1);

      // 5: overflow with 9 pushes into 8 entries
      do_reset();
      for (int i = 0; i < 9; i++) begin
         send_frame(8'h40 + 8'(i), 1'b0, 1'b1);
         if (i == 7) check_eq("t5_nofull_ovf", {31'd0, overflow}, 32'd0);
      end
      check_eq("t5_ovf", {31'd0, overflow}, 32'd1);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      check_eq("t5_clr", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         pop_expect($sformatf("t5_pop%0d", i), 1'b0, 1'b0, 8'h40 + 8'(i));
      end
      check_eq("t5_empty", {31'd0, out_valid}, 32'd0);

      // 6: reset mid-frame with a non-empty FIFO, pending prefix and nonzero errors
      do_reset();
      send_frame(8'h10, 1'b0, 1'b1);
      send_frame(8'h11, 1'b1, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_raw(frame_bits(8'h55, 1'b0, 1'b1), 4);
      check_eq("t6_pre_err", {24'd0, err_cnt}, 32'd1);
      rst = 1'b1;
      tick(1);
      check_eq("t6_valid", {31'd0, out_valid}, 32'd0);
      check_eq("t6_entry", {22'd0, out_ext, out_brk, out_code}, 32'd0);
      check_eq("t6_ovf", {31'd0, overflow}, 32'd0);
      check_eq("t6_err", {24'd0, err_cnt}, 32'd0);
      rst = 1'b0;
      tick(1);
      send_frame(8'h1C, 1'b0, 1'b1);
      pop_expect("t6_noflag", 1'b0, 1'b0, 8'h1C);
      for (int i = 0; i < 300; i++) begin
         send_frame(8'h1C, 1'b0, 1'b0);
         if (i == 253) check_eq("t6_err254", {24'd0, err_cnt}, 32'd254);
      end
      check_eq("t6_sat", {24'd0, err_cnt}, 32'd255);
      check_eq("t6_nopush", {31'd0, out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
